// File: rtl/smart_lighting_pkg.sv
// Shared types and default timing constants for the smart lighting controller.
package smart_lighting_pkg;

  // Controller states: automatic (IR driven) and manual (button driven).
  typedef enum logic [1:0] {
    AutoIdle,
    AutoOn,
    ManualOff,
    ManualOn
  } state_t;

  // Default cycle counts at a 1 kHz clock.
  localparam int unsigned DefDebounceCycles  = 50;
  localparam int unsigned DefLongPressCycles = 3000;
  localparam int unsigned DefAutoOffCycles   = 30000;

endpackage

// File: rtl/smart_lighting_top_button_conditioner.sv
// Push-button front end: 2-FF synchronizer, debounce, short/long press classification.
module button_conditioner
  import smart_lighting_pkg::*;
#(
  parameter int unsigned DebounceCycles  = DefDebounceCycles,
  parameter int unsigned LongPressCycles = DefLongPressCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic short_evt_o,
  output logic long_evt_o
);

  localparam int unsigned DbW   = $clog2(DebounceCycles + 1);
  localparam int unsigned HoldW = $clog2(LongPressCycles + 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongPressCycles);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressCycles - 1);

  logic             sync1_q, sync2_q;
  logic             btn_db_q, btn_db_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;

  // Debounce: flip only after DebounceCycles consecutive disagreeing samples.
  // Hold: count press length, saturating at LongPressCycles; cleared while released.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    hold_d   = hold_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
    if (btn_db_q) begin
      if (hold_q != HoldMax) hold_d = hold_q + HoldW'(1);
    end else begin
      hold_d = '0;
    end
  end

  // Long fires on the edge the hold count reaches the limit; short fires in the first
  // released cycle, while hold_q still carries the finished press length.
  always_comb begin
    long_evt_o  = btn_db_q && (hold_q == HoldLast);
    short_evt_o = !btn_db_q && (hold_q != '0) && (hold_q != HoldMax);
  end

  // Synchronizer, debounce and hold state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
      hold_q   <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/smart_lighting_top.sv
// Smart room-lighting controller: IR-driven automatic mode with hold-off timer,
// button-driven manual mode, long press toggles between them.
module smart_lighting_top
  import smart_lighting_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
  parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles,
  parameter int unsigned AUTO_OFF_CYCLES   = DefAutoOffCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infravermelho,
  output logic led,
  output logic saida
);

  localparam int unsigned TmrW = $clog2(AUTO_OFF_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(AUTO_OFF_CYCLES);

  logic            short_evt, long_evt;
  logic            ir_sync1_q, ir_s_q;
  state_t          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            led_q, led_d, saida_q, saida_d;

  button_conditioner #(
    .DebounceCycles (DEBOUNCE_CYCLES),
    .LongPressCycles(LONG_PRESS_CYCLES)
  ) u_button_conditioner (
    .clk_i      (clk),
    .rst_i      (rst),
    .btn_i      (push_button),
    .short_evt_o(short_evt),
    .long_evt_o (long_evt)
  );

  // Next state and hold-off timer; long_evt has priority over IR and short presses.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      AutoIdle: begin
        if (long_evt) begin
          state_d = ManualOff;
          timer_d = '0;
        end else if (ir_s_q) begin
          state_d = AutoOn;
          timer_d = TmrLoad;
        end
      end
      AutoOn: begin
        if (long_evt) begin
          state_d = ManualOff;
          timer_d = '0;
        end else if (ir_s_q) begin
          timer_d = TmrLoad;
        end else if (timer_q == '0) begin
          state_d = AutoIdle;
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
      end
      ManualOff: begin
        if (long_evt) begin
          state_d = AutoIdle;
          timer_d = '0;
        end else if (short_evt) begin
          state_d = ManualOn;
        end
      end
      ManualOn: begin
        if (long_evt) begin
          state_d = AutoIdle;
          timer_d = '0;
        end else if (short_evt) begin
          state_d = ManualOff;
        end
      end
      default: begin
        state_d = AutoIdle;
        timer_d = '0;
      end
    endcase
  end

  // Output decode from the next state so led/saida come straight from flops.
  always_comb begin
    saida_d = (state_d == AutoOn) || (state_d == ManualOn);
    led_d   = (state_d == ManualOff) || (state_d == ManualOn);
  end

  // IR synchronizer, FSM, timer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sync1_q <= 1'b0;
      ir_s_q     <= 1'b0;
      state_q    <= AutoIdle;
      timer_q    <= '0;
      led_q      <= 1'b0;
      saida_q    <= 1'b0;
    end else begin
      ir_sync1_q <= infravermelho;
      ir_s_q     <= ir_sync1_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      saida_q    <= saida_d;
    end
  end

  assign led   = led_q;
  assign saida = saida_q;

endmodule

// File: tb/tb_smart_lighting_top.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle compared
// against a timestamp-based behavioural model of the controller.
module tb_smart_lighting_top;

  localparam int unsigned D = 4;
  localparam int unsigned L = 40;
  localparam int unsigned N = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_button = 1'b0;
  logic infravermelho = 1'b0;
  logic led, saida;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  smart_lighting_top #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .AUTO_OFF_CYCLES  (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .infravermelho(infravermelho),
    .led          (led),
    .saida        (saida)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: pin values delayed two edges, press lengths and IR hold-off
  // tracked as edge timestamps.
  int e_cnt = 0;
  int m_run = 0, m_rise = 0, m_fall = 0, m_last_ir = 0;
  bit m_db = 0, m_fall_pend = 0, m_manual = 0, m_lamp = 0, m_ir_valid = 0;
  bit ir_p1 = 0, ir_p2 = 0, bt_p1 = 0, bt_p2 = 0;
  bit m_led = 0, m_saida = 0;

  always @(posedge clk) begin : model
    bit ir_s, bt_s, long_now, short_now;
    ir_s = ir_p2;
    bt_s = bt_p2;
    e_cnt++;
    if (rst) begin
      ir_p1 = 0; ir_p2 = 0; bt_p1 = 0; bt_p2 = 0;
      m_db = 0; m_run = 0; m_fall_pend = 0;
      m_manual = 0; m_lamp = 0; m_ir_valid = 0;
    end else begin
      long_now  = m_db && (e_cnt - m_rise == int'(L));
      short_now = m_fall_pend && (m_fall - m_rise < int'(L));
      m_fall_pend = 0;
      if (bt_s != m_db) begin
        m_run++;
        if (m_run == int'(D)) begin
          m_db  = bt_s;
          m_run = 0;
          if (m_db) m_rise = e_cnt;
          else begin
            m_fall = e_cnt;
            m_fall_pend = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      if (!m_manual) begin
        if (long_now) begin
          m_manual = 1;
          m_lamp = 0;
        end else if (ir_s) begin
          m_last_ir = e_cnt;
          m_ir_valid = 1;
        end
      end else begin
        if (long_now) begin
          m_manual = 0;
          m_ir_valid = 0;
        end else if (short_now) begin
          m_lamp = !m_lamp;
        end
      end
      ir_p2 = ir_p1; ir_p1 = infravermelho;
      bt_p2 = bt_p1; bt_p1 = push_button;
    end
    m_led   = m_manual;
    m_saida = m_manual ? m_lamp : (m_ir_valid && (e_cnt - m_last_ir <= int'(N)));
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("model_led", led, m_led);
      check_eq("model_saida", saida, m_saida);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    push_button = 1'b1;
    cyc(n);
    push_button = 1'b0;
    cyc(int'(D) + 6);
  endtask

  int bt_left = 0;
  int ir_left = 0;

  initial begin
    // Reset: outputs low during and after reset.
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_eq("reset_led", led, 1'b0);
    check_eq("reset_saida", saida, 1'b0);
    cyc(4);
    rst = 1'b0;
    cyc(3);
    check_eq("post_reset_saida", saida, 1'b0);

    // Auto on: saida rises on the third edge after the pin rises.
    infravermelho = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_eq("latency_2edges", saida, 1'b0);
    @(posedge clk); @(negedge clk);
    check_eq("latency_3edges", saida, 1'b1);
    cyc(7);
    infravermelho = 1'b0;
    cyc(int'(N) - 5);
    check_eq("holdoff_still_on", saida, 1'b1);
    cyc(20);
    check_eq("holdoff_expired", saida, 1'b0);

    // Retrigger keeps the lamp on through the second hold-off.
    infravermelho = 1'b1; cyc(5); infravermelho = 1'b0;
    cyc(100);
    infravermelho = 1'b1; cyc(5); infravermelho = 1'b0;
    cyc(int'(N) - 10);
    check_eq("retrigger_on", saida, 1'b1);
    cyc(30);
    check_eq("retrigger_off", saida, 1'b0);

    // Bounce shorter than the debounce window changes nothing.
    for (int i = 0; i < 20; i++) begin
      push_button = ~push_button;
      cyc(2);
    end
    push_button = 1'b0;
    cyc(10);
    check_eq("bounce_led", led, 1'b0);
    check_eq("bounce_saida", saida, 1'b0);

    // Long press enters manual; short presses toggle the lamp; IR ignored.
    press(int'(L) + 20);
    check_eq("manual_led", led, 1'b1);
    check_eq("manual_off", saida, 1'b0);
    press(15);
    check_eq("manual_on", saida, 1'b1);
    press(15);
    check_eq("manual_off_again", saida, 1'b0);
    infravermelho = 1'b1; cyc(10); infravermelho = 1'b0; cyc(10);
    check_eq("manual_ir_ignored", saida, 1'b0);
    check_eq("manual_led_kept", led, 1'b1);

    // Long press with IR held returns to auto and lights immediately.
    infravermelho = 1'b1;
    press(int'(L) + 20);
    check_eq("return_led", led, 1'b0);
    check_eq("return_saida", saida, 1'b1);
    infravermelho = 1'b0;
    cyc(int'(N) + 10);
    check_eq("return_holdoff", saida, 1'b0);

    // Random stimulus, including bounces, long presses and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      if (bt_left == 0) begin
        push_button = ($urandom_range(0, 2) == 0);
        bt_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D))
                                               : int'($urandom_range(D, L + 15));
      end
      if (ir_left == 0) begin
        infravermelho = ($urandom_range(0, 3) == 0);
        ir_left = int'($urandom_range(1, 200));
      end
      rst = ($urandom_range(0, 999) == 0);
      bt_left--;
      ir_left--;
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
